// File: rtl/seq_alu.sv
// Multicycle execute-stage ALU with valid/ready handshakes on both sides.
// Logic/arithmetic ops finish in one cycle; shifts step one bit per cycle.
module seq_alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int unsigned SW = $clog2(XLEN);
    localparam logic [SW-1:0] CntOne = SW'(1);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpXor  = 4'b0101;
    localparam logic [3:0] OpSlt  = 4'b1100;
    localparam logic [3:0] OpSltu = 4'b1101;
    localparam logic [3:0] OpSll  = 4'b1010;
    localparam logic [3:0] OpSrl  = 4'b1000;
    localparam logic [3:0] OpSra  = 4'b1001;

    localparam logic [1:0] ShSll = 2'd0;
    localparam logic [1:0] ShSrl = 2'd1;
    localparam logic [1:0] ShSra = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [1:0]      sh_q, sh_d;
    logic            illegal_q, illegal_d;
    logic            zero_q;

    logic            accept;
    logic            is_shift;
    logic [SW-1:0]   shamt;
    logic            slt_s;
    logic            slt_u;

    assign accept   = in_valid & in_ready;
    assign is_shift = (op == OpSll) | (op == OpSrl) | (op == OpSra);
    assign shamt    = b[SW-1:0];
    assign slt_s    = $signed(a) < $signed(b);
    assign slt_u    = a < b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            sh_q      <= ShSll;
            illegal_q <= 1'b0;
            zero_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            illegal_q <= illegal_d;
            zero_q    <= (acc_d == '0);
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (state_q == StDone && out_ready) begin
                    state_d = StIdle;
                end
                if (accept) begin
                    state_d   = StDone;
                    illegal_d = 1'b0;
                    cnt_d     = '0;
                    if (is_shift) begin
                        // Operand a is loaded and shifted in place; shamt==0 completes at once.
                        acc_d = a;
                        cnt_d = shamt;
                        sh_d  = (op == OpSll) ? ShSll : ((op == OpSra) ? ShSra : ShSrl);
                        if (shamt != '0) begin
                            state_d = StShift;
                        end
                    end else begin
                        case (op)
                            OpAnd:   acc_d = a & b;
                            OpOr:    acc_d = a | b;
                            OpAdd:   acc_d = a + b;
                            OpSub:   acc_d = a - b;
                            OpXor:   acc_d = a ^ b;
                            OpSlt:   acc_d = {{(XLEN-1){1'b0}}, slt_s};
                            OpSltu:  acc_d = {{(XLEN-1){1'b0}}, slt_u};
                            default: begin
                                acc_d     = '0;
                                illegal_d = 1'b1;
                            end
                        endcase
                    end
                end
            end
            StShift: begin
                case (sh_q)
                    ShSll:   acc_d = {acc_q[XLEN-2:0], 1'b0};
                    ShSra:   acc_d = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
                    default: acc_d = {1'b0, acc_q[XLEN-1:1]};
                endcase
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle:  in_ready = 1'b1;
            StDone: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign result  = acc_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;

endmodule
